// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-stage load/store unit.
// Access size, fault causes and the registered request bundle.
package mem_stage_lsu_pkg;

    localparam int LSU_XLEN  = 32;
    localparam int LSU_REG_W = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        FC_NONE        = 2'b00,
        FC_LD_MISALIGN = 2'b01,
        FC_ST_MISALIGN = 2'b10,
        FC_TIMEOUT     = 2'b11
    } fault_cause_e;

    typedef struct packed {
        logic [LSU_XLEN-1:0]  addr;
        logic [LSU_XLEN-1:0]  wdata;
        logic [3:0]           be;
        logic                 we;
        logic [2:0]           funct3;
        logic [LSU_REG_W-1:0] rd;
        logic                 reg_write;
    } lsu_req_s;

    typedef struct packed {
        logic [LSU_XLEN-1:0]  alu_result;
        logic [LSU_XLEN-1:0]  store_data;
        logic                 mem_read;
        logic                 mem_write;
        logic [2:0]           funct3;
        logic                 reg_write;
        logic [LSU_REG_W-1:0] rd;
    } ex_to_mem_s;

    // Unused encodings (011, 110, 111) fall through to word.
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        unique case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane shaping for stores, lane extraction/extension for loads,
// and natural-alignment check. Purely combinational.
import mem_stage_lsu_pkg::*;

module mem_stage_lsu_lane_align (
    input  logic [31:0] addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    lsu_size_e   size;
    logic [1:0]  off;
    logic [31:0] shifted;

    assign size    = lsu_size(funct3_i);
    assign off     = addr_i[1:0];
    assign shifted = rdata_i >> {off, 3'b000};

    always_comb begin
        wdata_o    = sdata_i;
        be_o       = 4'hF;
        ldata_o    = shifted;
        misalign_o = 1'b0;
        unique case (size)
            SZ_B: begin
                wdata_o = {4{sdata_i[7:0]}};
                be_o    = 4'b0001 << off;
                ldata_o = funct3_i[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata_o    = {2{sdata_i[15:0]}};
                be_o       = 4'b0011 << off;
                ldata_o    = funct3_i[2] ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                misalign_o = off[0];
            end
            SZ_W: begin
                misalign_o = (off != 2'b00);
            end
            default: begin
                misalign_o = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipelined memory stage: variable-latency req/ack data port,
// sub-word accesses, misalignment and bus-timeout faults.
import mem_stage_lsu_pkg::*;

module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic              in_reg_write,
    input  logic [REG_W-1:0]  in_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              fault_valid,
    output logic [1:0]        fault_cause,
    output logic [XLEN-1:0]   fault_addr
);

    if (XLEN != LSU_XLEN) begin : g_xlen_chk
        $error("mem_stage_lsu: XLEN must be 32");
    end
    if (REG_W != LSU_REG_W) begin : g_regw_chk
        $error("mem_stage_lsu: REG_W must be 5");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e       state_q, state_d;
    lsu_req_s     req_q, req_d;
    logic         dmem_req_q, dmem_req_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic         wb_valid_q, wb_valid_d;
    logic         wb_reg_write_q, wb_reg_write_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic         fault_valid_q, fault_valid_d;
    fault_cause_e fault_cause_q, fault_cause_d;
    logic [XLEN-1:0]  fault_addr_q, fault_addr_d;

    ex_to_mem_s  ex;
    logic [31:0] al_addr;
    logic [2:0]  al_funct3;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_ldata;
    logic        al_misalign;
    logic        is_mem;
    logic        tmo_hit;

    assign ex = '{
        alu_result: in_alu_result,
        store_data: in_store_data,
        mem_read:   in_mem_read,
        mem_write:  in_mem_write,
        funct3:     in_funct3,
        reg_write:  in_reg_write,
        rd:         in_rd
    };

    // One aligner serves both paths: incoming op in IDLE, held request in WAIT.
    assign al_addr   = (state_q == S_WAIT) ? req_q.addr   : ex.alu_result;
    assign al_funct3 = (state_q == S_WAIT) ? req_q.funct3 : ex.funct3;

    mem_stage_lsu_lane_align u_align (
        .addr_i     (al_addr),
        .funct3_i   (al_funct3),
        .sdata_i    (ex.store_data),
        .rdata_i    (dmem_rdata),
        .wdata_o    (al_wdata),
        .be_o       (al_be),
        .ldata_o    (al_ldata),
        .misalign_o (al_misalign)
    );

    assign is_mem  = ex.mem_read | ex.mem_write;
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        dmem_req_d     = dmem_req_q;
        cnt_d          = cnt_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        fault_valid_d  = 1'b0;
        fault_cause_d  = fault_cause_q;
        fault_addr_d   = fault_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex.reg_write;
                        wb_rd_d        = ex.rd;
                        wb_data_d      = ex.alu_result;
                    end else if (al_misalign) begin
                        fault_valid_d = 1'b1;
                        fault_cause_d = ex.mem_read ? FC_LD_MISALIGN
                                                    : FC_ST_MISALIGN;
                        fault_addr_d  = ex.alu_result;
                    end else begin
                        req_d.addr      = ex.alu_result;
                        req_d.wdata     = al_wdata;
                        req_d.be        = al_be;
                        req_d.we        = ~ex.mem_read;
                        req_d.funct3    = ex.funct3;
                        req_d.rd        = ex.rd;
                        req_d.reg_write = ex.reg_write;
                        dmem_req_d      = 1'b1;
                        cnt_d           = '0;
                        state_d         = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    dmem_req_d     = 1'b0;
                    state_d        = S_IDLE;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = req_q.reg_write & ~req_q.we;
                    wb_rd_d        = req_q.rd;
                    if (!req_q.we) wb_data_d = al_ldata;
                end else if (tmo_hit) begin
                    dmem_req_d    = 1'b0;
                    state_d       = S_IDLE;
                    fault_valid_d = 1'b1;
                    fault_cause_d = FC_TIMEOUT;
                    fault_addr_d  = req_q.addr;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            req_q          <= '0;
            dmem_req_q     <= 1'b0;
            cnt_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            fault_valid_q  <= 1'b0;
            fault_cause_q  <= FC_NONE;
            fault_addr_q   <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            dmem_req_q     <= dmem_req_d;
            cnt_q          <= cnt_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            fault_valid_q  <= fault_valid_d;
            fault_cause_q  <= fault_cause_d;
            fault_addr_q   <= fault_addr_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = req_q.we;
    assign dmem_addr    = {req_q.addr[XLEN-1:2], 2'b00};
    assign dmem_wdata   = req_q.wdata;
    assign dmem_be      = req_q.be;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign fault_valid  = fault_valid_q;
    assign fault_cause  = fault_cause_q;
    assign fault_addr   = fault_addr_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Pipelined RISC-V memory stage with a full load/store unit. It sits between the execute stage and the writeback stage. It adds three things over the single-cycle memory stage: byte/halfword/word accesses with sign/zero extension, a variable-latency req/ack data-memory port with upstream stall, and misalignment/timeout fault reporting. Non-memory instructions pass through in one cycle.

Parameters:
XLEN, 32, datapath and address width (32 only; asserted at elaboration)
REG_W, 5, destination register index width
TIMEOUT, 16, max cycles waiting for dmem_ack before bus fault; 0 disables timeout
TMO_W, $clog2(TIMEOUT+1), wait-counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  execute-stage instruction valid
in_ready  out  1  stage can accept (low = stall execute)
in_alu_result  in  XLEN  effective address or ALU result
in_store_data  in  XLEN  rs2 value for stores
in_mem_read  in  1  load
in_mem_write  in  1  store
in_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
in_reg_write  in  1  writes rd
in_rd  in  REG_W  destination register
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  write request
dmem_addr  out  XLEN  word-aligned address (low 2 bits zero)
dmem_wdata  out  XLEN  store data replicated into lanes
dmem_be  out  XLEN/8  byte enables
dmem_ack  in  1  request complete; rdata valid same cycle for reads
dmem_rdata  in  XLEN  read word
wb_valid  out  1  writeback entry valid
wb_reg_write  out  1  qualified by wb_valid
wb_rd  out  REG_W  destination
wb_data  out  XLEN  load result or ALU result
fault_valid  out  1  one-cycle fault pulse
fault_cause  out  2  01 load misalign, 10 store misalign, 11 bus timeout
fault_addr  out  XLEN  faulting byte address

Behaviour:
- Reset (async, rst_n low): state IDLE. wb_valid, wb_reg_write, dmem_req, dmem_we, fault_valid = 0. wb_rd, wb_data, dmem_addr, dmem_wdata, dmem_be, fault_cause, fault_addr = 0. Wait counter = 0.
- FSM states IDLE, WAIT. in_ready = (state==IDLE).
- IDLE, in_valid, no mem op: next edge wb_valid=1, wb_data=in_alu_result, wb_reg_write=in_reg_write, wb_rd=in_rd. Latency 1.
- IDLE, in_valid, mem op, aligned: next edge the request is registered, dmem_req=1, state→WAIT. Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0. wb_valid=0 while waiting.
- IDLE, in_valid, misaligned: no dmem request. Next edge fault_valid=1 with the matching cause and fault_addr=in_alu_result. wb_valid=0. State stays IDLE.
- Store lane shaping: B sets be=1<<addr[1:0] and wdata=4 copies of byte. H sets be=2'b11<<addr[1:0] and wdata=2 copies of half. W sets be=4'hF.
- WAIT: dmem_req and all dmem_* outputs stay stable until dmem_ack. On the ack edge: dmem_req=0, state→IDLE. Loads then get wb_valid=1, wb_data=extracted lane (B/H sign-extended, BU/HU zero-extended), wb_reg_write and wb_rd from the registered request. Stores get wb_valid=1 with wb_reg_write=0. Load latency = 1 + ack wait cycles, minimum 2.
- Timeout (TIMEOUT>0): counter increments each WAIT cycle without ack. The edge on which the count reaches TIMEOUT drops dmem_req, pulses fault_valid with cause 11 and the registered byte address, and moves to IDLE with no writeback. An ack arriving on that same cycle wins; no fault.
- in_valid=0 in IDLE: wb_valid=0 next edge. Inputs are ignored in WAIT, and upstream must hold them.
- Both mem_read and mem_write set: treated as a load.
- Unused funct3 values (011, 110, 111) are treated as W.
- fault_valid and wb_valid are never high in the same cycle.
- rst_n asserted mid-WAIT: request dropped immediately, no writeback, no fault.

Decomposition:
- Add lsu_size_e (B/H/W), fault_cause_e, and an lsu_req_s struct (addr, wdata, be, we, funct3, rd, reg_write) to riscv_structures.sv. ex_to_mem_s is unchanged; the top level unpacks it.
- Sub-module lsu_lane_align (combinational): store replication/byte enables, load extraction/extension, misalignment detect. It is shared by the store and load paths.
- FSM, wait counter and pipeline registers live in mem_stage_lsu.

Test Plan:
- ADD result 0x0000_1234, rd=5, reg_write=1, no mem → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, in_ready stays 1.
- SB addr 0x103, data 0x0000_00A5, ack after 3 cycles → dmem_addr=0x100, be=4'b1000, wdata=0xA5A5_A5A5. in_ready low for 3 cycles. wb_valid=1 with reg_write=0.
- LB addr 0x102, rdata 0x0080_0000, ack same cycle as req → wb_data=0xFFFF_FF80 two cycles after accept. LBU at the same address → 0x0000_0080.
- LH addr 0x201 → fault_valid=1, cause=01, fault_addr=0x201, no dmem_req, in_ready stays 1. SW addr 0x202 → cause=10.
- LW with TIMEOUT=16 and no ack → dmem_req high exactly 16 cycles, then fault cause=11, no wb_valid. Repeat with ack on cycle 16 → normal writeback, no fault.
- rst_n pulled low while in WAIT → dmem_req=0 and all wb/fault outputs 0 asynchronously. After release the next ADD completes normally.
